// File: rtl/prog_mem_loader.sv
// Purpose: program memory for the 8-bit core, filled at run time from a byte stream.
// Latency: reads return one cycle after a strobe; loadReady/cpuRun/loadCount are registered.
// Backpressure: loadReady is high for the whole LOAD state; loadValid low stalls the load indefinitely.
//
// Ports:
//   clk, resetN            - single clock, synchronous active-low reset
//   memAddr, memStrobe     - processor fetch request (sampled at posedge)
//   memDataRead            - registered fetch data, holds when not strobed
//   loadStart              - begin a load at address 0 (from IDLE or RUN)
//   loadValid, loadData,   - byte stream; a byte is taken when loadValid & loadReady
//   loadLast, loadReady
//   loadCount              - bytes accepted in the current or last load
//   cpuRun                 - processor may run; low while idle or loading
module prog_mem_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int LOAD_LEN   = 256
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic [ADDR_WIDTH-1:0] memAddr,
  input  logic                  memStrobe,
  output logic [7:0]            memDataRead,
  input  logic                  loadStart,
  input  logic                  loadValid,
  input  logic [7:0]            loadData,
  input  logic                  loadLast,
  output logic                  loadReady,
  output logic [ADDR_WIDTH:0]   loadCount,
  output logic                  cpuRun
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  // loadCount value at which the incoming byte is the LOAD_LEN-th one.
  localparam logic [ADDR_WIDTH:0] LAST_COUNT = (ADDR_WIDTH+1)'(LOAD_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t                state;
  state_t                stateNext;
  logic [7:0]            mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wrPtr;
  logic                  accept;
  logic                  finalByte;
  logic                  enterLoad;

  assign accept    = (state == LOAD) && loadValid;
  assign finalByte = accept && (loadLast || (loadCount == LAST_COUNT));

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (loadStart) stateNext = LOAD;
      LOAD:    if (finalByte) stateNext = RUN;
      RUN:     if (loadStart) stateNext = LOAD;
      default: stateNext = IDLE;
    endcase
  end

  // Every entry into LOAD restarts the fill at address 0.
  assign enterLoad = (state != LOAD) && (stateNext == LOAD);

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state     <= IDLE;
      loadReady <= 1'b0;
      cpuRun    <= 1'b0;
      loadCount <= '0;
      wrPtr     <= '0;
    end else begin
      state     <= stateNext;
      // Outputs follow the next state so they are registered yet aligned with it.
      loadReady <= (stateNext == LOAD);
      cpuRun    <= (stateNext == RUN);
      if (enterLoad) begin
        wrPtr     <= '0;
        loadCount <= '0;
      end else if (accept) begin
        // wrPtr wraps to 0 on a full-depth load, coinciding with the move to RUN.
        wrPtr     <= wrPtr + 1'b1;
        loadCount <= loadCount + 1'b1;
      end
    end
  end

  // Memory contents survive reset; only the write is blocked while reset is asserted.
  always_ff @(posedge clk) begin
    if (resetN && accept) begin
      mem[wrPtr] <= loadData;
    end
  end

  // Non-blocking read of the array gives read-before-write on a same-address collision.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      memDataRead <= 8'h00;
    end else if (memStrobe) begin
      memDataRead <= mem[memAddr];
    end
  end

endmodule

// File: tb/tb_prog_mem_loader.sv
module tb_prog_mem_loader;

  logic       clk = 1'b0;
  logic       resetN;
  logic [7:0] memAddr;
  logic       memStrobe;
  logic [7:0] memDataRead;
  logic       loadStart;
  logic       loadValid;
  logic [7:0] loadData;
  logic       loadLast;
  logic       loadReady;
  logic [8:0] loadCount;
  logic       cpuRun;

  int tests = 0;
  int fails = 0;

  prog_mem_loader #(.ADDR_WIDTH(8), .LOAD_LEN(256)) dut (
    .clk(clk), .resetN(resetN), .memAddr(memAddr), .memStrobe(memStrobe),
    .memDataRead(memDataRead), .loadStart(loadStart), .loadValid(loadValid),
    .loadData(loadData), .loadLast(loadLast), .loadReady(loadReady),
    .loadCount(loadCount), .cpuRun(cpuRun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // The load is viewed as "a stream currently filling memory" plus
  // "a program that has been released to the processor".
  logic [7:0] mdlMem   [256];
  bit         mdlKnown [256];
  bit         synced   = 0;
  bit         filling  = 0;
  bit         released = 0;
  int         bytesIn  = 0;
  logic [7:0] expRead  = 8'h00;
  bit         readKnown = 1;

  always @(posedge clk) begin
    if (resetN === 1'b0) begin
      synced    = 1;
      filling   = 0;
      released  = 0;
      bytesIn   = 0;
      expRead   = 8'h00;
      readKnown = 1;
    end else begin
      if (memStrobe) begin
        expRead   = mdlMem[memAddr];
        readKnown = mdlKnown[memAddr];
      end
      if (filling) begin
        if (loadValid) begin
          mdlMem[bytesIn % 256]   = loadData;
          mdlKnown[bytesIn % 256] = 1;
          bytesIn++;
          if (loadLast || bytesIn == 256) begin
            filling  = 0;
            released = 1;
          end
        end
      end else if (loadStart) begin
        filling  = 1;
        released = 0;
        bytesIn  = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (synced) begin
      check("mdl_loadReady", 32'(loadReady), 32'(filling));
      check("mdl_cpuRun", 32'(cpuRun), 32'(released));
      check("mdl_loadCount", 32'(loadCount), 32'(bytesIn));
      if (readKnown) check("mdl_memDataRead", 32'(memDataRead), 32'(expRead));
    end
  end

  // ---------------- directed stimulus with literal expectations ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    loadStart = 0; loadValid = 0; loadLast = 0; loadData = 8'h00;
    memStrobe = 0; memAddr = 8'h00;
  endtask

  task automatic sendByte(input logic [7:0] d, input logic last);
    loadValid = 1; loadData = d; loadLast = last;
    tick();
    loadValid = 0; loadLast = 0;
  endtask

  task automatic readAt(input logic [7:0] a, input logic [7:0] exp, input string name);
    memStrobe = 1; memAddr = a;
    tick();
    memStrobe = 0;
    check(name, 32'(memDataRead), 32'(exp));
  endtask

  logic [7:0] prog [10] = '{8'h0C, 8'h0A, 8'h1C, 8'h14, 8'h02, 8'h01, 8'hFF, 8'h8D, 8'h00, 8'h02};

  initial begin
    resetN = 0;
    idleInputs();
    loadStart = 1;

    // Reset with loadStart held: must stay in IDLE.
    tick(); tick();
    check("rst_cpuRun", 32'(cpuRun), 32'd0);
    check("rst_loadReady", 32'(loadReady), 32'd0);
    check("rst_memDataRead", 32'(memDataRead), 32'h00);
    check("rst_loadCount", 32'(loadCount), 32'd0);
    resetN = 1; loadStart = 0;
    tick();
    check("idle_loadReady", 32'(loadReady), 32'd0);

    // Short program with loadLast on the 10th byte.
    loadStart = 1; tick(); loadStart = 0;
    check("start_loadReady", 32'(loadReady), 32'd1);
    for (int i = 0; i < 10; i++) begin
      sendByte(prog[i], i == 9);
      if (i == 8) check("short_cpuRun_before", 32'(cpuRun), 32'd0);
    end
    check("short_cpuRun", 32'(cpuRun), 32'd1);
    check("short_loadReady", 32'(loadReady), 32'd0);
    check("short_loadCount", 32'(loadCount), 32'd10);
    for (int i = 0; i < 10; i++) readAt(8'(i), prog[i], "short_read");

    // Stalled stream: 3 bytes, 5 idle cycles, 3 more bytes.
    loadStart = 1; tick(); loadStart = 0;
    for (int i = 0; i < 3; i++) sendByte(8'h30 + 8'(i), 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_loadCount", 32'(loadCount), 32'd3);
      check("stall_loadReady", 32'(loadReady), 32'd1);
    end
    for (int i = 3; i < 6; i++) sendByte(8'h30 + 8'(i), i == 5);
    check("stall_loadCount_end", 32'(loadCount), 32'd6);
    for (int i = 0; i < 6; i++) readAt(8'(i), 8'h30 + 8'(i), "stall_read");

    // Full 256-byte load, no loadLast.
    loadStart = 1; tick(); loadStart = 0;
    for (int i = 0; i < 256; i++) begin
      sendByte(8'(i), 1'b0);
      if (i == 254) check("full_cpuRun_before", 32'(cpuRun), 32'd0);
    end
    check("full_cpuRun", 32'(cpuRun), 32'd1);
    check("full_loadCount", 32'(loadCount), 32'd256);
    readAt(8'hFF, 8'hFF, "full_read_ff");
    readAt(8'h00, 8'h00, "full_read_00");

    // Reload from RUN, then a same-address read/write collision.
    loadStart = 1; tick(); loadStart = 0;
    check("reload_cpuRun", 32'(cpuRun), 32'd0);
    check("reload_loadCount", 32'(loadCount), 32'd0);
    memStrobe = 1; memAddr = 8'h00;
    sendByte(8'hAA, 1'b0);
    memStrobe = 0;
    check("collide_old", 32'(memDataRead), 32'h00);
    readAt(8'h00, 8'hAA, "collide_new");

    // Reset after the 3rd byte of this load.
    sendByte(8'h11, 1'b0);
    sendByte(8'h22, 1'b0);
    check("midload_count", 32'(loadCount), 32'd3);
    resetN = 0; loadValid = 1; loadData = 8'h77;
    tick();
    resetN = 1; loadValid = 0;
    check("midrst_loadCount", 32'(loadCount), 32'd0);
    check("midrst_cpuRun", 32'(cpuRun), 32'd0);
    check("midrst_loadReady", 32'(loadReady), 32'd0);
    readAt(8'h00, 8'hAA, "midrst_read0");
    readAt(8'h01, 8'h11, "midrst_read1");
    readAt(8'h02, 8'h22, "midrst_read2");

    // Randomized traffic, checked cycle by cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      resetN    = ($urandom_range(0, 299) != 0);
      loadStart = ($urandom_range(0, 39) == 0);
      loadValid = $urandom_range(0, 1) == 1;
      loadData  = 8'($urandom);
      loadLast  = ($urandom_range(0, 29) == 0);
      memStrobe = $urandom_range(0, 1) == 1;
      memAddr   = 8'($urandom);
      tick();
    end
    idleInputs();
    resetN = 1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
